// File: rtl/seq_pattern_generator_pkg.sv
// rtl/seq_pattern_generator_pkg.sv - shared encodings and constants for the serial pattern link
// Holds FSM state encodings, default pattern, PRBS-7 seed/taps and LED history width.
package seq_pattern_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b11010;
  localparam logic [6:0] PRBS7_SEED      = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS      = 7'b1100000;
  localparam int         LED_W           = 5;

  // x^7 + x^6 + 1 Fibonacci step; the bit leaving s[6] is the emitted PRBS bit
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// rtl/seq_bit_timer.sv - bit-period down-counter
// load restarts the period at div; tick marks the last clock of the period.
module seq_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/seq_pattern_generator.sv
// rtl/seq_pattern_generator.sv - serial test-pattern transmitter, MSB first, with repeats and gaps
// Optional SEQ_GEN_PRBS_EN: gap bits come from a PRBS-7 LFSR instead of constant 0.
module seq_pattern_generator
  import seq_pattern_generator_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [DIV_W-1:0] bit_div,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [LED_W-1:0] LED_seq_out
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  seq_state_t       state, state_next;
  logic [PAT_W-1:0] sh_pat;
  logic [GAP_W-1:0] sh_gap, gap_left;
  logic [DIV_W-1:0] sh_div;
  logic [CNT_W-1:0] rep_left;
  logic [IDX_W-1:0] idx;
  logic             tick, emit, emit_val, gap_bit;
  logic             capture, idx_step, pat_end, gap_step, gap_emit;
  logic             last_bit, last_rep;

  assign last_bit = (idx == '0);
  // rep_left stays 0 in continuous mode, so the last repetition is never reached
  assign last_rep = (rep_left == CNT_W'(1));

`ifdef SEQ_GEN_PRBS_EN
  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PRBS7_SEED;
    end else if (gap_emit) begin
      lfsr <= prbs7_step(lfsr);
    end
  end

  assign gap_bit = lfsr[6];
`else
  assign gap_bit = 1'b0;
`endif

  seq_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (emit),
    .div   ((state == ST_IDLE) ? bit_div : sh_div),
    .tick  (tick)
  );

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_val   = 1'b0;
    capture    = 1'b0;
    idx_step   = 1'b0;
    pat_end    = 1'b0;
    gap_step   = 1'b0;
    gap_emit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_SHIFT;
          capture    = 1'b1;
          emit       = 1'b1;
          emit_val   = pattern[PAT_W-1];
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (!last_bit) begin
            idx_step = 1'b1;
            emit     = 1'b1;
            emit_val = sh_pat[idx - 1'b1];
          end else begin
            pat_end = 1'b1;
            if (last_rep) begin
              state_next = ST_DONE;
            end else if (sh_gap != '0) begin
              state_next = ST_GAP;
              emit       = 1'b1;
              gap_emit   = 1'b1;
              emit_val   = gap_bit;
            end else begin
              emit     = 1'b1;
              emit_val = sh_pat[PAT_W-1];
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          gap_step = 1'b1;
          emit     = 1'b1;
          if (gap_left == GAP_W'(1)) begin
            state_next = ST_SHIFT;
            emit_val   = sh_pat[PAT_W-1];
          end else begin
            gap_emit = 1'b1;
            emit_val = gap_bit;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_out     <= 1'b0;
      bit_valid   <= 1'b0;
      LED_seq_out <= '0;
      sh_pat      <= '0;
      sh_gap      <= '0;
      sh_div      <= '0;
      rep_left    <= '0;
      gap_left    <= '0;
      idx         <= '0;
    end else begin
      bit_valid <= emit;
      if (emit) begin
        seq_out     <= emit_val;
        LED_seq_out <= {LED_seq_out[LED_W-2:0], emit_val};
      end else if (state_next == ST_IDLE || state_next == ST_DONE) begin
        seq_out <= 1'b0;
      end
      if (capture) begin
        sh_pat   <= pattern;
        sh_gap   <= gap_len;
        sh_div   <= bit_div;
        rep_left <= rep_cnt;
        idx      <= IDX_MSB;
      end
      if (idx_step) idx <= idx - 1'b1;
      if (pat_end) begin
        idx      <= IDX_MSB;
        gap_left <= sh_gap;
        if (rep_left != '0) rep_left <= rep_left - 1'b1;
      end
      if (gap_step) gap_left <= gap_left - 1'b1;
    end
  end

  assign busy = (state == ST_SHIFT) || (state == ST_GAP);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_generator.sv
// tb/tb_seq_pattern_generator.sv - self-checking bench for seq_pattern_generator
// Expected bit streams are built per run from the pattern/rep/gap rules and checked cycle by cycle.
module tb_seq_pattern_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  pattern = '0;
  logic [7:0]  rep_cnt = '0;
  logic [3:0]  gap_len = '0;
  logic [15:0] bit_div = '0;
  logic        seq_out, bit_valid, busy, done;
  logic [4:0]  LED_seq_out;

  int checks = 0;
  int errors = 0;
  logic [6:0] m_lfsr = 7'h7F;

  seq_pattern_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .rep_cnt     (rep_cnt),
    .gap_len     (gap_len),
    .bit_div     (bit_div),
    .seq_out     (seq_out),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .done        (done),
    .LED_seq_out (LED_seq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic next_gap_bit();
    logic b = 1'b0;
`ifdef SEQ_GEN_PRBS_EN
    b = m_lfsr[6];
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`endif
    return b;
  endfunction

  task automatic run_seq(input logic [4:0] pat, input int rep, input int gap, input int div,
                         input bit start_in_done);
    logic q[$];
    logic [4:0] exp_led;
    int n;
    for (int r = 0; r < rep; r++) begin
      for (int b = 4; b >= 0; b--) q.push_back(pat[b]);
      if (r != rep - 1)
        for (int g = 0; g < gap; g++) q.push_back(next_gap_bit());
    end
    pattern = pat; rep_cnt = 8'(rep); gap_len = 4'(gap); bit_div = 16'(div); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = 5'($urandom); rep_cnt = 8'($urandom); gap_len = 4'($urandom); bit_div = 16'($urandom);
    foreach (q[i]) begin
      for (int c = 0; c <= div; c++) begin
        check("seq_out", seq_out, q[i]);
        check("bit_valid", bit_valid, (c == 0));
        check("busy", busy, 1);
        check("done_early", done, 0);
        @(posedge clk); #1;
      end
    end
    n = q.size();
    for (int i = 0; i < 5; i++) exp_led[i] = q[n-1-i];
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("seq_at_done", seq_out, 0);
    check("led", LED_seq_out, exp_led);
    if (start_in_done) begin
      start = 1'b1; pattern = 5'b10000; bit_div = 16'd0; rep_cnt = 8'd1;
    end
    @(posedge clk); #1;
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    if (start_in_done) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("late_start_busy", busy, 1);
      check("late_start_bit", seq_out, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("late_abort_busy", busy, 0);
      check("late_abort_seq", seq_out, 0);
    end
  endtask

  task automatic run_abort();
    logic [4:0] pat = 5'b10110;
    logic [4:0] hist;
    logic       e;
    hist = LED_seq_out;
    pattern = pat; rep_cnt = 8'd0; gap_len = 4'd0; bit_div = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = pat[4 - (i % 5)];
      check("cont_seq", seq_out, e);
      check("cont_valid", bit_valid, 1);
      check("cont_busy", busy, 1);
      check("cont_done", done, 0);
      hist = {hist[3:0], e};
      start = (i == 3);
      pattern = (i == 3) ? 5'b01001 : pat;
      abort = (i == 11);
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    check("abort_seq", seq_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_led", LED_seq_out, hist);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
  endtask

  initial begin
    #1;
    check("rst_seq", seq_out, 0);
    check("rst_busy", busy, 0);
    check("rst_led", LED_seq_out, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(5'b11010, 1, 0, 0, 1'b0);
    run_seq(5'b11010, 3, 2, 0, 1'b0);
    run_seq(5'b11010, 1, 0, 3, 1'b0);
    run_seq(5'b11010, 2, 7, 0, 1'b0);
    run_seq(5'b10011, 2, 1, 1, 1'b1);

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_ignored", busy, 0);

    run_abort();

    for (int t = 0; t < 8; t++)
      run_seq(5'($urandom_range(0, 31)), $urandom_range(1, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'b0);

    pattern = 5'b11010; rep_cnt = 8'd1; gap_len = 4'd0; bit_div = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", busy, 1);
    #1 rst_n = 1'b0;
    m_lfsr = 7'h7F;
    #1;
    check("mid_rst_seq", seq_out, 0);
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_led", LED_seq_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq(5'b11010, 1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
